// File: rtl/qs_insts_pkg.sv
// Shared microengine instruction types, field encodings and predecode helpers.
package qs_insts_pkg;

  localparam int QS_PC_W   = 8;
  localparam int QS_INST_W = 16;

  typedef logic [QS_PC_W-1:0]   pc_t;
  typedef logic [QS_INST_W-1:0] inst_t;
  typedef logic [3:0]           op_t;
  typedef logic [1:0]           cc_t;

  localparam op_t OP_J       = 4'b0001;
  localparam op_t OP_CALLRET = 4'b1100;

  localparam cc_t CC_U  = 2'b00;
  localparam cc_t CC_EQ = 2'b01;
  localparam cc_t CC_GT = 2'b10;
  localparam cc_t CC_LE = 2'b11;

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } fetch_st_e;

  function automatic logic is_ju(inst_t i);
    return (i[15:12] == OP_J) && (i[9:8] == CC_U);
  endfunction

  // Anything execute must resolve before fetch may continue.
  function automatic logic is_ctl(inst_t i);
    return ((i[15:12] == OP_J) && (i[9:8] != CC_U)) || (i[15:12] == OP_CALLRET);
  endfunction

  function automatic pc_t jmp_target(inst_t i);
    return i[QS_PC_W-1:0];
  endfunction

endpackage

// File: rtl/qs_ucode_fetch_if.sv
// Fetch-stage bus: ROM port, issue handshake to decode, branch resolution from execute.
interface qs_ucode_fetch_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 16
);
  logic [PC_W-1:0]   rom_ra;
  logic [INST_W-1:0] rom_rout;
  logic              inst_vld;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_rdy;
  logic              br_vld;
  logic              br_taken;
  logic [PC_W-1:0]   br_pc;

  modport master (
    output rom_ra, inst_vld, inst, inst_pc,
    input  rom_rout, inst_rdy, br_vld, br_taken, br_pc
  );

  modport slave (
    input  rom_ra, inst_vld, inst, inst_pc,
    output rom_rout, inst_rdy, br_vld, br_taken, br_pc
  );
endinterface

// File: rtl/qs_fetch_outreg.sv
// One-entry valid/ready pipeline register; 1-cycle latency, full throughput,
// output held stable while out_rdy is low.
module qs_fetch_outreg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) out_dat <= in_dat;
    end
  end

endmodule

// File: rtl/qs_ucode_fetch.sv
// Microcode fetch/sequencer: folds unconditional jumps, issues the rest with 1-cycle
// latency, stalls on downstream backpressure and stops after any control transfer until resolved.
module qs_ucode_fetch
  import qs_insts_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  qs_ucode_fetch_if.master  fif
);

  if (PC_W != $bits(pc_t) || INST_W != $bits(inst_t)) begin : g_width_chk
    $error("qs_ucode_fetch: PC_W/INST_W do not match qs_insts_pkg types");
  end

  fetch_st_e         state, state_nxt;
  logic [PC_W-1:0]   pc_r, pc_nxt;
  logic              free;
  logic              issue;
  inst_t             rout;
  logic [INST_W+PC_W-1:0] out_dat;

  assign rout       = fif.rom_rout;
  assign fif.rom_ra = pc_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      pc_r  <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc_r  <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_r;
    issue     = 1'b0;
    case (state)
      ST_RUN: begin
        if (free) begin
          if (is_ju(rout)) begin
            pc_nxt = jmp_target(rout);
          end else begin
            issue  = 1'b1;
            pc_nxt = pc_r + PC_W'(1);
            if (is_ctl(rout)) state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // pc_r already points at the fall-through slot.
        if (fif.br_vld) begin
          if (fif.br_taken) pc_nxt = fif.br_pc;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  qs_fetch_outreg #(.W(INST_W + PC_W)) u_outreg (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (issue),
    .in_dat  ({rout, pc_r}),
    .in_rdy  (free),
    .out_vld (fif.inst_vld),
    .out_dat (out_dat),
    .out_rdy (fif.inst_rdy)
  );

  assign fif.inst    = out_dat[INST_W+PC_W-1:PC_W];
  assign fif.inst_pc = out_dat[PC_W-1:0];

  a_no_br_in_run: assert property (@(posedge clk) disable iff (rst)
    !(fif.br_vld && state == ST_RUN));

endmodule
